// File: rtl/word_match_stream_if.sv
// Stream bundle for word_match_stream: upstream word handshake, downstream result handshake
// and the status outputs. CNT_W must match the CNT_W of the attached word_match_stream.
interface word_match_stream_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_word;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_word;
  logic             out_match;
  logic [CNT_W-1:0] match_count;
  logic             run_hit;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_word, out_match, match_count, run_hit
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_word, out_match, match_count, run_hit
  );
endinterface

// File: rtl/word_match_stream.sv
// Registered single-stage stream that compares each accepted word with PATTERN, counts
// matches with saturation and flags runs of at least RUN_LEN consecutive matches.
module word_match_stream #(
  parameter logic [31:0] PATTERN = 32'h0000ABCD,
  parameter int          CNT_W   = 16,
  parameter int          RUN_LEN = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  word_match_stream_if.slave    bus
);

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2
  } run_state_t;

  localparam logic [7:0]       RUN_LEN_B = 8'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  run_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       accept;
  logic       is_match;
  logic       hit_d;
  word_t      word_in;

  assign word_in  = bus.in_word;
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept   = bus.in_valid && bus.in_ready;
  assign is_match = (word_in == PATTERN);

  // Run tracker: clear wins over a same-cycle accept, so that word never advances the run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (is_match) begin
            state_d = RUN;
            cnt_d   = 8'd1;
          end
        end
        RUN: begin
          if (is_match) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q + 8'd1 == RUN_LEN_B) begin
              state_d = HIT;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        end
        HIT: begin
          if (!is_match) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  assign hit_d = accept && !clear && (state_d == HIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output register: load on accept, otherwise drop valid once the result is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_word  <= '0;
      bus.out_match <= 1'b0;
      bus.run_hit   <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_word  <= word_in;
      bus.out_match <= is_match;
      bus.run_hit   <= hit_d;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      bus.match_count <= '0;
    end else if (accept && is_match && (bus.match_count != CNT_MAX)) begin
      bus.match_count <= bus.match_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_word_match_stream.sv
// Bench for word_match_stream: table-driven stream vectors checked through a result
// scoreboard, plus hand-written backpressure, clear, reset and saturation sequences.
module tb_word_match_stream;

  typedef struct {
    logic [31:0] word;
    logic        clr;
    logic        exp_match;
    logic        exp_hit;
    logic [15:0] exp_count;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    logic        match;
    logic        hit;
    logic [15:0] count;
  } res_t;

  localparam int NUM_VECS = 20;

  logic clk;
  logic rst;
  logic clear;
  int   checks = 0;
  int   errors = 0;
  res_t sb[$];
  vec_t vecs[NUM_VECS];

  word_match_stream_if #(.CNT_W(16)) bus ();
  word_match_stream_if #(.CNT_W(4))  bus4 ();

  word_match_stream #(.PATTERN(32'h0000ABCD), .CNT_W(16), .RUN_LEN(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  word_match_stream #(.PATTERN(32'h0000ABCD), .CNT_W(4), .RUN_LEN(3)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Offer one word, wait (bounded) for acceptance, queue its expected result.
  task automatic applyStimulus(input logic [31:0] w, input logic clr, input logic em,
                               input logic eh, input logic [15:0] ec);
    int   waits = 0;
    res_t r;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    clear        = clr;
    while (!bus.in_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready got 0, want 1 within 20 cycles");
      bus.in_valid = 1'b0;
      clear        = 1'b0;
      return;
    end
    r.word  = w;
    r.match = em;
    r.hit   = eh;
    r.count = ec;
    sb.push_back(r);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    clear        = 1'b0;
    checkOutput("latency_valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("latency_word", bus.out_word, w);
  endtask

  // Scoreboard: compare every result at the cycle it is consumed.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result: got word %08h, want no result", bus.out_word);
      end else begin
        res_t e;
        e = sb.pop_front();
        checkOutput("sb_word", bus.out_word, e.word);
        checkOutput("sb_match", {31'd0, bus.out_match}, {31'd0, e.match});
        checkOutput("sb_run_hit", {31'd0, bus.run_hit}, {31'd0, e.hit});
        checkOutput("sb_count", {16'd0, bus.match_count}, {16'd0, e.count});
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{32'h0000ABCD, 1'b0, 1'b1, 1'b0, 16'd1};
    vecs[1]  = '{32'h00001234, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[2]  = '{32'h0000ABCD, 1'b0, 1'b1, 1'b0, 16'd2};
    vecs[3]  = '{32'h00000000, 1'b0, 1'b0, 1'b0, 16'd2};
    vecs[4]  = '{32'h0000ABCD, 1'b0, 1'b1, 1'b0, 16'd3};
    vecs[5]  = '{32'h0000ABCD, 1'b0, 1'b1, 1'b0, 16'd4};
    vecs[6]  = '{32'h0000ABCD, 1'b0, 1'b1, 1'b1, 16'd5};
    vecs[7]  = '{32'h0000ABCD, 1'b0, 1'b1, 1'b1, 16'd6};
    vecs[8]  = '{32'h00000000, 1'b0, 1'b0, 1'b0, 16'd6};
    vecs[9]  = '{32'h0001ABCD, 1'b0, 1'b0, 1'b0, 16'd6};
    vecs[10] = '{32'h0000ABCC, 1'b0, 1'b0, 1'b0, 16'd6};
    vecs[11] = '{32'h8000ABCD, 1'b0, 1'b0, 1'b0, 16'd6};
    vecs[12] = '{32'h0000ABCD, 1'b0, 1'b1, 1'b0, 16'd7};
    vecs[13] = '{32'h0000ABCD, 1'b0, 1'b1, 1'b0, 16'd8};
    vecs[14] = '{32'h0000ABCD, 1'b1, 1'b1, 1'b0, 16'd0};
    vecs[15] = '{32'h0000ABCD, 1'b0, 1'b1, 1'b0, 16'd1};
    vecs[16] = '{32'h0000ABCD, 1'b0, 1'b1, 1'b0, 16'd2};
    vecs[17] = '{32'h0000ABCD, 1'b0, 1'b1, 1'b1, 16'd3};
    vecs[18] = '{32'h00001234, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[19] = '{32'h0000ABCD, 1'b0, 1'b1, 1'b0, 16'd1};

    // Reset with a word offered: it must not be taken into state.
    rst           = 1'b1;
    clear         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_word   = 32'h0000ABCD;
    bus.out_ready = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.in_word   = 32'h0000ABCD;
    bus4.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_word", bus.out_word, 32'd0);
    checkOutput("rst_out_match", {31'd0, bus.out_match}, 32'd0);
    checkOutput("rst_run_hit", {31'd0, bus.run_hit}, 32'd0);
    checkOutput("rst_count", {16'd0, bus.match_count}, 32'd0);
    checkOutput("rst_in_ready_after", {31'd0, bus.in_ready}, 32'd1);

    // Saturation on the 4-bit counter instance.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      bus4.in_valid = (i < 17);
      @(posedge clk);
      #1;
      checkOutput("sat_count", {28'd0, bus4.match_count}, (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    bus4.in_valid = 1'b0;

    // Continuous flow through the vector table.
    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].word, vecs[i].clr, vecs[i].exp_match, vecs[i].exp_hit,
                    vecs[i].exp_count);
      checkOutput("flow_in_ready", {31'd0, bus.in_ready}, 32'd1);
    end
    @(posedge clk);
    #1;
    checkOutput("valid_drop", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure: hold the result, refuse a second word, then replace with no gap.
    bus.out_ready = 1'b0;
    applyStimulus(32'h0000ABCD, 1'b0, 1'b1, 1'b0, 16'd2);
    bus.in_valid = 1'b1;
    bus.in_word  = 32'h00001234;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      checkOutput("stall_word", bus.out_word, 32'h0000ABCD);
      checkOutput("stall_match", {31'd0, bus.out_match}, 32'd1);
      checkOutput("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      checkOutput("stall_count", {16'd0, bus.match_count}, 32'd2);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    sb.push_back('{32'h00001234, 1'b0, 1'b0, 16'd2});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checkOutput("replace_valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("replace_word", bus.out_word, 32'h00001234);
    @(posedge clk);
    #1;
    checkOutput("replace_drop", {31'd0, bus.out_valid}, 32'd0);

    // Clear while a result is pending leaves the result untouched.
    bus.out_ready = 1'b0;
    applyStimulus(32'h0000ABCD, 1'b0, 1'b1, 1'b0, 16'd3);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    checkOutput("clr_count", {16'd0, bus.match_count}, 32'd0);
    checkOutput("clr_valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("clr_word", bus.out_word, 32'h0000ABCD);
    checkOutput("clr_match", {31'd0, bus.out_match}, 32'd1);

    // Reset while stalled discards the pending result.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    checkOutput("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("midrst_count", {16'd0, bus.match_count}, 32'd0);
    checkOutput("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    applyStimulus(32'h0000ABCD, 1'b0, 1'b1, 1'b0, 16'd1);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
